mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter N, default 32, data and address width in bits.
REQ-002 Parameter LAT, default 1, memory access cycles per transaction; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch requester wants a read.
REQ-006 if_addr  input  N  fetch address; held stable while if_req is high.
REQ-007 dm_req  input  1  data-memory requester wants an access.
REQ-008 dm_we  input  1  data access is a write (1) or read (0); held with dm_req.
REQ-009 dm_addr  input  N  data address; held stable while dm_req is high.
REQ-010 dm_wdata  input  N  write data; held stable while dm_req is high.
REQ-011 mem_rdata  input  N  read data from the shared single-port memory.
REQ-012 sel  output  1  address/data mux select to the shared port: 0 = fetch, 1 = data.
REQ-013 mem_en  output  1  memory port enable.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  N  address to memory.
REQ-016 mem_wdata  output  N  write data to memory.
REQ-017 if_done  output  1  one-cycle completion pulse for fetch; if_rdata valid in that cycle.
REQ-018 dm_done  output  1  one-cycle completion pulse for data access; dm_rdata valid in that cycle on reads.
REQ-019 if_rdata, dm_rdata  output  N each  read data returned to each requester.
REQ-020 if_stall, dm_stall  output  1 each  pipeline stall: x_req high and x_done low.

Function
REQ-021 FSM states: IDLE, BUSY_IF, BUSY_DM; 4-bit down-counter cnt; register last (0 = fetch served last, 1 = data).
REQ-022 IDLE, only if_req: next BUSY_IF, cnt loads LAT-1.
REQ-023 IDLE, only dm_req: next BUSY_DM, cnt loads LAT-1.
REQ-024 IDLE, both requests: grant side opposite to last (round-robin); last updates on grant.
REQ-025 IDLE, no request: stay IDLE.
REQ-026 BUSY_x, cnt > 0: decrement cnt, stay.
REQ-027 BUSY_x, cnt == 0: x_done = 1 (combinational from state and cnt), next state IDLE.
REQ-028 Latency: req first seen in IDLE at cycle 0; BUSY cycles 1..LAT; done in cycle LAT; earliest next grant evaluated in cycle LAT+1 (one IDLE cycle between transactions).
REQ-029 sel = 1 in BUSY_DM, 0 otherwise; mem_en = 1 in any BUSY state.
REQ-030 mem_addr = if_addr in BUSY_IF, dm_addr in BUSY_DM, 0 in IDLE.
REQ-031 mem_we = dm_we only in BUSY_DM; mem_wdata = dm_wdata in BUSY_DM, else 0.
REQ-032 if_rdata = mem_rdata when if_done else 0; dm_rdata = mem_rdata when dm_done and not dm_we, else 0.
REQ-033 Requester deasserting req mid-transaction: no abort; transaction completes, done pulse still issued.
REQ-034 Write in progress is never issued twice; a requester holding req after done is re-arbitrated as a new request.
REQ-035 No requester waits more than one other transaction under continuous contention.

Reset
REQ-036 reset high forces immediately, without clock: state IDLE, cnt 0, last 0.
REQ-037 All outputs 0 during reset, including sel, mem_en, mem_we.
REQ-038 Reset mid-transaction: access abandoned, no done pulse; after release, first contention grants data side.

Verification
REQ-039 LAT=1, if_req alone, if_addr=0x00400000, mem_rdata=0x8C010004 -> cycle 1: mem_en=1, sel=0, if_done=1, if_rdata=0x8C010004.
REQ-040 LAT=3, dm_req=1, dm_we=1, dm_addr=0x10010000, dm_wdata=0xDEADBEEF -> mem_we=1 cycles 1-3, dm_done only in cycle 3, dm_rdata=0.
REQ-041 LAT=1, both requests held continuously from reset -> grants alternate DM, IF, DM, IF; done pulses at cycles 1, 3, 5, 7.
REQ-042 LAT=3, reset asserted in cycle 2 of BUSY_IF -> mem_en=0 immediately, if_done never asserted, state IDLE.
REQ-043 LAT=2, dm_req dropped in cycle 1 of read -> dm_done still pulses in cycle 2, next cycle IDLE, mem_en=0.
REQ-044 if_req held with no completion pending -> if_stall=1 every cycle except done cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, data memory) for one shared
// single-port memory. One transaction at a time, LAT busy cycles each,
// and round-robin between the requesters when both are waiting.
//
// Handshake: a requester raises x_req and holds its address/data stable.
// x_done is a one-cycle pulse in the last busy cycle of its transaction.
// Once a transaction is granted it always runs to completion, even if
// x_req drops. A requester that still holds x_req after x_done is treated
// as a new request in the next IDLE cycle.
module mem_port_arbiter #(
  parameter int N   = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  input  logic         dm_req,
  input  logic         dm_we,
  input  logic [N-1:0] dm_addr,
  input  logic [N-1:0] dm_wdata,
  input  logic [N-1:0] mem_rdata,
  output logic         sel,
  output logic         mem_en,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         if_done,
  output logic         dm_done,
  output logic [N-1:0] if_rdata,
  output logic [N-1:0] dm_rdata,
  output logic         if_stall,
  output logic         dm_stall,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  // The counter is loaded with LAT-1 so that the busy phase lasts LAT cycles.
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       last_q,  last_d;   // 0: fetch served last, 1: data served last

  logic busy_if;
  logic busy_dm;

  assign busy_if     = (state_q == BUSY_IF);
  assign busy_dm     = (state_q == BUSY_DM);
  assign dbg_state_o = state_q;

  // State, counter and round-robin registers; reset clears them at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next state: arbitrate in IDLE, count down while busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // With both requesting, serve the side that was not served last.
        if (if_req && (!dm_req || last_q)) begin
          state_d = BUSY_IF;
          cnt_d   = CNT_LOAD;
          last_d  = 1'b0;
        end else if (dm_req) begin
          state_d = BUSY_DM;
          cnt_d   = CNT_LOAD;
          last_d  = 1'b1;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory port drive and requester responses, all derived from state.
  always_comb begin
    sel       = busy_dm;
    mem_en    = busy_if || busy_dm;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (busy_if) begin
      mem_addr = if_addr;
    end else if (busy_dm) begin
      mem_addr  = dm_addr;
      mem_we    = dm_we;
      mem_wdata = dm_wdata;
    end
    if_done  = busy_if && (cnt_q == 4'd0);
    dm_done  = busy_dm && (cnt_q == 4'd0);
    if_rdata = if_done ? mem_rdata : '0;
    dm_rdata = (dm_done && !dm_we) ? mem_rdata : '0;
    // Stall is masked during reset so every output reads 0 then.
    if_stall = !reset && if_req && !if_done;
    dm_stall = !reset && dm_req && !dm_done;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances with LAT = 1, 2, 3
// share one clock; each has its own reset and stimulus. Inputs change on
// the falling edge and outputs are sampled 1 time unit later, so each
// falling edge starts a new cycle (cycle 0 = request first seen in IDLE).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst       [3];
  logic        if_req    [3];
  logic [31:0] if_addr   [3];
  logic        dm_req    [3];
  logic        dm_we     [3];
  logic [31:0] dm_addr   [3];
  logic [31:0] dm_wdata  [3];
  logic [31:0] mem_rdata [3];
  logic        sel       [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic        if_done   [3];
  logic        dm_done   [3];
  logic [31:0] if_rdata  [3];
  logic [31:0] dm_rdata  [3];
  logic        if_stall  [3];
  logic        dm_stall  [3];
  logic [1:0]  dbg_state [3];

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_IF   = 32'd1;
  localparam logic [31:0] ST_DM   = 32'd2;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.N(32), .LAT(g + 1)) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .if_req     (if_req[g]),
      .if_addr    (if_addr[g]),
      .dm_req     (dm_req[g]),
      .dm_we      (dm_we[g]),
      .dm_addr    (dm_addr[g]),
      .dm_wdata   (dm_wdata[g]),
      .mem_rdata  (mem_rdata[g]),
      .sel        (sel[g]),
      .mem_en     (mem_en[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .if_done    (if_done[g]),
      .dm_done    (dm_done[g]),
      .if_rdata   (if_rdata[g]),
      .dm_rdata   (dm_rdata[g]),
      .if_stall   (if_stall[g]),
      .dm_stall   (dm_stall[g]),
      .dbg_state_o(dbg_state[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle's drive point.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 3; i++) begin
      rst[i]       = 1'b1;
      if_req[i]    = 1'b0;
      if_addr[i]   = 32'd0;
      dm_req[i]    = 1'b0;
      dm_we[i]     = 1'b0;
      dm_addr[i]   = 32'd0;
      dm_wdata[i]  = 32'd0;
      mem_rdata[i] = 32'd0;
    end

    // Reset: every output 0 even with a request pending.
    if_req[0]    = 1'b1;
    mem_rdata[0] = 32'h5555_AAAA;
    next_cycle(); #1;
    check("rst_state",    32'(dbg_state[0]), ST_IDLE);
    check("rst_mem_en",   32'(mem_en[0]),    0);
    check("rst_sel",      32'(sel[0]),       0);
    check("rst_mem_we",   32'(mem_we[0]),    0);
    check("rst_if_stall", 32'(if_stall[0]),  0);
    check("rst_if_rdata", if_rdata[0],       0);
    if_req[0] = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // LAT=1 single fetch.
    next_cycle();
    if_req[0]    = 1'b1;
    if_addr[0]   = 32'h0040_0000;
    mem_rdata[0] = 32'h8C01_0004;
    #1;
    check("f1_c0_state",  32'(dbg_state[0]), ST_IDLE);
    check("f1_c0_mem_en", 32'(mem_en[0]),    0);
    check("f1_c0_stall",  32'(if_stall[0]),  1);
    check("f1_c0_addr",   mem_addr[0],       0);
    next_cycle(); #1;
    check("f1_c1_mem_en", 32'(mem_en[0]),   1);
    check("f1_c1_sel",    32'(sel[0]),      0);
    check("f1_c1_addr",   mem_addr[0],      32'h0040_0000);
    check("f1_c1_done",   32'(if_done[0]),  1);
    check("f1_c1_rdata",  if_rdata[0],      32'h8C01_0004);
    check("f1_c1_stall",  32'(if_stall[0]), 0);
    if_req[0] = 1'b0;
    next_cycle(); #1;
    check("f1_c2_state",  32'(dbg_state[0]), ST_IDLE);
    check("f1_c2_mem_en", 32'(mem_en[0]),    0);
    check("f1_c2_done",   32'(if_done[0]),   0);

    // LAT=1 continuous contention from reset: DM, IF, DM, IF.
    rst[0]       = 1'b1;
    if_req[0]    = 1'b1;
    dm_req[0]    = 1'b1;
    dm_we[0]     = 1'b0;
    dm_addr[0]   = 32'h1001_0000;
    mem_rdata[0] = 32'h1234_5678;
    exp_q = {32'd1, 32'd0, 32'd1, 32'd0};
    next_cycle();
    rst[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("rr_c%0d_if_done", c),  32'(if_done[0]),     32'(c % 4 == 3));
      check($sformatf("rr_c%0d_dm_done", c),  32'(dm_done[0]),     32'(c % 4 == 1));
      check($sformatf("rr_c%0d_sel", c),      32'(sel[0]),         32'(c % 4 == 1));
      check($sformatf("rr_c%0d_if_stall", c), 32'(if_stall[0]),    32'(c % 4 != 3));
      check($sformatf("rr_c%0d_dm_rdata", c), dm_rdata[0], (c % 4 == 1) ? 32'h1234_5678 : 32'd0);
      if ((if_done[0] || dm_done[0]) && exp_q.size() > 0)
        check($sformatf("rr_c%0d_order", c), 32'(dm_done[0]), exp_q.pop_front());
      next_cycle();
    end
    check("rr_all_served", 32'(exp_q.size()), 0);
    if_req[0] = 1'b0;
    dm_req[0] = 1'b0;

    // LAT=3 data write.
    dm_req[2]    = 1'b1;
    dm_we[2]     = 1'b1;
    dm_addr[2]   = 32'h1001_0000;
    dm_wdata[2]  = 32'hDEAD_BEEF;
    mem_rdata[2] = 32'hCAFE_F00D;
    #1;
    check("wr_c0_state",  32'(dbg_state[2]), ST_IDLE);
    check("wr_c0_mem_we", 32'(mem_we[2]),    0);
    check("wr_c0_stall",  32'(dm_stall[2]),  1);
    for (int c = 1; c <= 3; c++) begin
      next_cycle(); #1;
      check($sformatf("wr_c%0d_mem_we", c), 32'(mem_we[2]),  1);
      check($sformatf("wr_c%0d_sel", c),    32'(sel[2]),     1);
      check($sformatf("wr_c%0d_addr", c),   mem_addr[2],     32'h1001_0000);
      check($sformatf("wr_c%0d_wdata", c),  mem_wdata[2],    32'hDEAD_BEEF);
      check($sformatf("wr_c%0d_done", c),   32'(dm_done[2]), 32'(c == 3));
      check($sformatf("wr_c%0d_rdata", c),  dm_rdata[2],     0);
      if (c == 3) dm_req[2] = 1'b0;
    end
    next_cycle(); #1;
    check("wr_c4_state",  32'(dbg_state[2]), ST_IDLE);
    check("wr_c4_mem_we", 32'(mem_we[2]),    0);
    check("wr_c4_mem_en", 32'(mem_en[2]),    0);
    next_cycle(); #1;
    check("wr_c5_mem_en", 32'(mem_en[2]),    0);

    // LAT=3 reset in the middle of a fetch.
    dm_we[2]   = 1'b0;
    if_req[2]  = 1'b1;
    if_addr[2] = 32'h0040_0010;
    next_cycle(); #1;
    check("rf_c1_state",  32'(dbg_state[2]), ST_IF);
    check("rf_c1_mem_en", 32'(mem_en[2]),    1);
    next_cycle();
    rst[2]    = 1'b1;
    if_req[2] = 1'b0;
    #1;
    check("rf_c2_mem_en", 32'(mem_en[2]),    0);
    check("rf_c2_done",   32'(if_done[2]),   0);
    check("rf_c2_state",  32'(dbg_state[2]), ST_IDLE);
    next_cycle();
    rst[2] = 1'b0;
    #1;
    check("rf_c3_done",   32'(if_done[2]),   0);
    next_cycle(); #1;
    check("rf_c4_done",   32'(if_done[2]),   0);
    check("rf_c4_state",  32'(dbg_state[2]), ST_IDLE);

    // Reset after a data grant clears last: contention then serves data.
    dm_req[2] = 1'b1;
    next_cycle(); #1;
    check("rd_c1_state", 32'(dbg_state[2]), ST_DM);
    next_cycle();
    rst[2]    = 1'b1;
    dm_req[2] = 1'b0;
    #1;
    check("rd_rst_done", 32'(dm_done[2]), 0);
    next_cycle();
    rst[2]    = 1'b0;
    if_req[2] = 1'b1;
    dm_req[2] = 1'b1;
    #1;
    check("rd_c0_state", 32'(dbg_state[2]), ST_IDLE);
    next_cycle(); #1;
    check("rd_c1_sel",   32'(sel[2]),       1);
    check("rd_c1_grant", 32'(dbg_state[2]), ST_DM);
    if_req[2] = 1'b0;
    dm_req[2] = 1'b0;

    // LAT=2 data read with request dropped after cycle 1.
    next_cycle();
    dm_req[1]    = 1'b1;
    dm_we[1]     = 1'b0;
    dm_addr[1]   = 32'h1001_0040;
    mem_rdata[1] = 32'h0BAD_F00D;
    #1;
    check("dr_c0_state", 32'(dbg_state[1]), ST_IDLE);
    next_cycle(); #1;
    check("dr_c1_sel",   32'(sel[1]),      1);
    check("dr_c1_addr",  mem_addr[1],      32'h1001_0040);
    check("dr_c1_done",  32'(dm_done[1]),  0);
    check("dr_c1_stall", 32'(dm_stall[1]), 1);
    check("dr_c1_rdata", dm_rdata[1],      0);
    dm_req[1] = 1'b0;
    next_cycle(); #1;
    check("dr_c2_done",   32'(dm_done[1]), 1);
    check("dr_c2_rdata",  dm_rdata[1],     32'h0BAD_F00D);
    check("dr_c2_mem_we", 32'(mem_we[1]),  0);
    next_cycle(); #1;
    check("dr_c3_state",  32'(dbg_state[1]), ST_IDLE);
    check("dr_c3_mem_en", 32'(mem_en[1]),    0);
    check("dr_c3_done",   32'(dm_done[1]),   0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
